// File: rtl/dmem_pkg.sv
// Shared definitions for the data-cache-to-memory line interface.
// Both the cache controller and the line responder import this package,
// so line width, line offset and the responder state encoding live here.
package dmem_pkg;

  localparam int LINE_BITS        = 256;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int ADDR_BITS        = 32;
  // Counter must hold LATENCY-1 for the full legal range 1..255.
  localparam int CNT_BITS         = 8;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_line_responder_if.sv
// Line request bus between the data cache controller (master) and the
// backing memory responder (slave).
//
// Handshake: the master raises mem_enable_i with mem_write_i, mem_addr_i and
// mem_data_i valid and keeps mem_enable_i high until it sees mem_ack_o. The
// slave samples the request once, at the edge it accepts it, and later
// returns a single-cycle mem_ack_o; for reads mem_data_o is valid in that
// same cycle. mem_ack_o acts as the ready/done for the whole transfer.
//
// Signals:
//   mem_enable_i  master->slave  request valid
//   mem_write_i   master->slave  1 = line write, 0 = line read
//   mem_addr_i    master->slave  byte address, bits [4:0] ignored
//   mem_data_i    master->slave  write line data
//   mem_ack_o     slave->master  one-cycle completion pulse
//   mem_data_o    slave->master  read line data, valid in the ack cycle
interface dmem_line_responder_if;
  import dmem_pkg::*;

  logic                 mem_enable_i;
  logic                 mem_write_i;
  logic [ADDR_BITS-1:0] mem_addr_i;
  line_t                mem_data_i;
  logic                 mem_ack_o;
  line_t                mem_data_o;

  modport master (
    output mem_enable_i,
    output mem_write_i,
    output mem_addr_i,
    output mem_data_i,
    input  mem_ack_o,
    input  mem_data_o
  );

  modport slave (
    input  mem_enable_i,
    input  mem_write_i,
    input  mem_addr_i,
    input  mem_data_i,
    output mem_ack_o,
    output mem_data_o
  );

endinterface : dmem_line_responder_if

// File: rtl/dmem_line_array.sv
// Single-port line storage: DEPTH lines of 256 bits with a synchronous write
// and a registered read. The read register holds its value until the next
// read, so writes never disturb the read data seen by the cache.
// Storage contents are not reset; only the read register is.
//
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-low reset (clears the read register only)
//   i_we     write enable, stores i_wdata at i_idx
//   i_re     read enable, loads o_rdata from i_idx
//   i_idx    line index
//   i_wdata  write line data
//   o_rdata  registered read line data
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  line_t                    i_wdata,
  output line_t                    o_rdata
);

  line_t r_mem [DEPTH];
  line_t r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule : dmem_line_array

// File: rtl/dmem_line_responder.sv
// Responder end of the data-cache line interface. Accepts one line read or
// write at a time, waits a fixed LATENCY edges, performs the access on the
// line array and pulses mem_ack_o for one cycle.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_i        asynchronous active-low reset
//   mem          line request bus (slave side)
//   o_dbg_state  current FSM state
//   o_dbg_count  current latency counter value
//
// Timing: a request accepted at edge T0 is performed at edge T0+LATENCY and
// acknowledged in the cycle that follows. The ACK state never samples
// mem_enable_i, so a master that holds enable through its ack cycle gets
// exactly one access per request.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dmem_line_responder_if.slave   mem,
  output state_e                 o_dbg_state,
  output logic [CNT_BITS-1:0]    o_dbg_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_BITS-1:0] LOAD_VAL = CNT_BITS'(LATENCY - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_BITS-1:0] r_count;
  logic [CNT_BITS-1:0] w_count_nxt;
  logic                r_write;
  logic [IDX_W-1:0]    r_idx;
  line_t               r_wdata;

  logic                w_accept;
  logic                w_access;
  logic                w_arr_we;
  logic                w_arr_re;
  logic [IDX_W-1:0]    w_req_idx;
  line_t               w_rdata;

  // Upper address bits alias; bits [4:0] select a byte within the line.
  assign w_req_idx = mem.mem_addr_i[LINE_OFFSET_BITS +: IDX_W];

  logic w_unused_addr;
  assign w_unused_addr = ^{mem.mem_addr_i[ADDR_BITS-1:LINE_OFFSET_BITS+IDX_W],
                           mem.mem_addr_i[LINE_OFFSET_BITS-1:0]};

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem.mem_enable_i) begin
          w_accept    = 1'b1;
          w_count_nxt = LOAD_VAL;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_count == '0) begin
          w_access    = 1'b1;
          w_state_nxt = ACK;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Request capture: inputs are only looked at in the acceptance cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= mem.mem_write_i;
      r_idx   <= w_req_idx;
      r_wdata <= mem.mem_data_i;
    end
  end

  // The access happens on the edge that enters ACK, so read data is already
  // registered when the ack pulse is visible. Reset leaves BUSY without ever
  // reaching this edge, which drops a pending write.
  assign w_arr_we = w_access &  r_write;
  assign w_arr_re = w_access & ~r_write;

  dmem_line_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign mem.mem_ack_o  = (r_state == ACK);
  assign mem.mem_data_o = w_rdata;

  assign o_dbg_state = r_state;
  assign o_dbg_count = r_count;

endmodule : dmem_line_responder
